// File: rtl/instr_load_encoder.sv
// Encodes DP/LDR/STR/B descriptors into ARM words and writes them to imem from BASE_ADDR; write is registered (1 cycle).
// Never back-pressures inside LOAD; holds the core in reset until the image completes.
module instr_load_encoder #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int DEPTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_cond,
  input  logic [1:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [23:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_reset_n,
  output logic              err,
  output logic [7:0]        err_count,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        accept, bad_dp, reject, wr, last_slot, start_load;
  logic [31:0] word;

  assign in_ready    = (state == S_LOAD);
  assign busy        = (state == S_LOAD);
  assign done        = (state == S_DONE);
  assign cpu_reset_n = done;

  assign accept     = in_valid && in_ready;
  assign start_load = start && (state != S_LOAD);
  assign last_slot  = (word_count == CNT_W'(DEPTH - 1));

  // Only ADD, SUB, AND and ORR are legal data-processing commands.
  always_comb begin
    bad_dp = 1'b1;
    case (in_funct[4:1])
      4'b0100, 4'b0010, 4'b0000, 4'b1100: bad_dp = 1'b0;
      default:                            bad_dp = 1'b1;
    endcase
  end

  assign reject = (in_op == 2'b11) || ((in_op == 2'b00) && bad_dp);
  assign wr     = accept && !reject;

  always_comb begin
    word = {in_cond, in_op, in_funct, in_rn, in_rd, in_imm[11:0]};
    if (in_op == 2'b10) begin
      word = {in_cond, 2'b10, in_funct[5:4], in_imm};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
      S_LOAD: if (accept && (in_last || (wr && last_slot))) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      err_count  <= '0;
      err        <= 1'b0;
    end else begin
      mem_we <= wr;
      if (start_load) begin
        word_count <= '0;
        err_count  <= '0;
        err        <= 1'b0;
      end else if (wr) begin
        mem_addr   <= BASE_ADDR + (ADDR_W'(word_count) << 2);
        mem_wdata  <= word;
        word_count <= word_count + CNT_W'(1);
        // Image truncated when the last slot fills without in_last.
        if (last_slot && !in_last) err <= 1'b1;
      end else if (accept) begin
        err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
